board_stream_tx: RTL

Position-stream transmitter for the move generator pipeline. It holds a 64-square board image written square-by-square by the host side. On `start` it serialises the board as a 64-beat position stream in FEN square order (a8..h8, a7..h7, …, a1..h1) with valid/ready flow control and start/end-of-packet markers. This is the producer for the `in_pos_*` stream consumed by the movegen front end.

---
 rtl/board_stream_tx_if.sv | 28 ++
 rtl/board_stream_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/board_stream_tx_if.sv
// Position-stream bus between board_stream_tx and the movegen front end.
// The rankfile signal exists only when BOARD_STREAM_TX_RANKFILE_EN is defined.
interface board_stream_tx_if;
  logic       valid;
  logic       ready;
  logic       sop;
  logic       eop;
  logic [3:0] data;
`ifdef BOARD_STREAM_TX_RANKFILE_EN
  logic [5:0] rankfile;
`endif

  modport master (
    input  ready,
    output valid, sop, eop, data
`ifdef BOARD_STREAM_TX_RANKFILE_EN
    , rankfile
`endif
  );

  modport slave (
    output ready,
    input  valid, sop, eop, data
`ifdef BOARD_STREAM_TX_RANKFILE_EN
    , rankfile
`endif
  );
endinterface

// File: rtl/board_stream_tx.sv
// Board image (64 x 4 bit) serialised as a 64-beat position stream in FEN order.
// Optional BOARD_STREAM_TX_RANKFILE_EN adds a registered square address per beat.
//
// state    | meaning
// S_IDLE   | board writable, stream idle
// S_STREAM | presenting beats 0..63, board frozen
module board_stream_tx (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_en,
  input  logic [5:0]                i_wr_rankfile,
  input  logic [3:0]                i_wr_piece,
  input  logic                      i_clear,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_wr_drop,
  board_stream_tx_if.master         out_pos
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t     r_state;
  logic [5:0] r_idx;
  logic [3:0] r_board [64];
  logic       r_busy;
  logic       r_valid;
  logic       r_sop;
  logic       r_eop;
  logic [3:0] r_data;
  logic       r_wr_drop;
`ifdef BOARD_STREAM_TX_RANKFILE_EN
  logic [5:0] r_rankfile;
`endif

  logic [5:0] w_idx_nx;
  logic [5:0] w_sq_nx;
  logic [3:0] w_a8_piece;

  // Beat i maps to rank 7-i[5:3]; inverting the 3-bit rank does that subtraction.
  assign w_idx_nx = r_idx + 6'd1;
  assign w_sq_nx  = {~w_idx_nx[5:3], w_idx_nx[2:0]};

  // Beat 0 must see a write or clear issued in the same cycle as start.
  always_comb begin
    w_a8_piece = r_board[6'o70];
    if (i_clear)
      w_a8_piece = 4'd0;
    if (i_wr_en && (i_wr_rankfile == 6'o70))
      w_a8_piece = i_wr_piece;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 6'd0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= 4'd0;
      r_wr_drop <= 1'b0;
`ifdef BOARD_STREAM_TX_RANKFILE_EN
      r_rankfile <= 6'd0;
`endif
      for (int j = 0; j < 64; j++)
        r_board[j] <= 4'd0;
    end else begin
      r_wr_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_clear)
            for (int j = 0; j < 64; j++)
              r_board[j] <= 4'd0;
          if (i_wr_en)
            r_board[i_wr_rankfile] <= i_wr_piece;
          if (i_start) begin
            r_state <= S_STREAM;
            r_idx   <= 6'd0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
            r_data  <= w_a8_piece;
`ifdef BOARD_STREAM_TX_RANKFILE_EN
            r_rankfile <= 6'o70;
`endif
          end
        end
        S_STREAM: begin
          if (i_wr_en || i_clear)
            r_wr_drop <= 1'b1;
          if (out_pos.ready) begin
            if (r_idx == 6'd63) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_sop   <= 1'b0;
              r_eop   <= 1'b0;
              r_data  <= 4'd0;
`ifdef BOARD_STREAM_TX_RANKFILE_EN
              r_rankfile <= 6'd0;
`endif
            end else begin
              r_idx  <= w_idx_nx;
              r_sop  <= 1'b0;
              r_eop  <= (w_idx_nx == 6'd63);
              r_data <= r_board[w_sq_nx];
`ifdef BOARD_STREAM_TX_RANKFILE_EN
              r_rankfile <= w_sq_nx;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_wr_drop     = r_wr_drop;
  assign out_pos.valid = r_valid;
  assign out_pos.sop   = r_sop;
  assign out_pos.eop   = r_eop;
  assign out_pos.data  = r_data;
`ifdef BOARD_STREAM_TX_RANKFILE_EN
  assign out_pos.rankfile = r_rankfile;
`endif

endmodule
